paso_n_a_m_param: RTL and testbench
===================================

Name: paso_n_a_m_param

Overview:
- Parametrised successor of the 8b->32b serial-to-parallel stage.
- Packs RATIO consecutive IN_W-bit input beats into one IN_W*RATIO-bit output word, on a single clock domain.
- Uses a valid/ready handshake on both sides instead of fixed clk_f/clk_4f rate coupling.
- Adds a selectable lane order, output backpressure, and a flush that emits partial words with a lane-keep mask. Sits between the byte-lane receive path and the wide-word consumer.

Parameters:
- IN_W, 8, width of one input beat in bits (>=1)
- RATIO, 4, beats per output word (>=2)
- MSB_FIRST, 1, 1: first accepted beat lands in the top lane; 0: first beat lands in lane 0 (bits IN_W-1:0)

Ports:
- clk_4f  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  IN_W  input beat
- valid_in  in  1  data_in is valid this cycle
- ready_in  out  1  block can accept a beat; transfer when valid_in && ready_in
- flush  in  1  close the current word early (level, sampled each cycle)
- data_out  out  IN_W*RATIO  packed output word
- keep_out  out  RATIO  bit k=1 means data_out[k*IN_W +: IN_W] holds a valid beat
- valid_out  out  1  data_out/keep_out valid
- ready_out  in  1  consumer accepts; transfer when valid_out && ready_out

Behaviour:
- Reset (synchronous, clk_4f edge with reset=1) clears every register:
  - data_out=0, keep_out=0, valid_out=0
  - accumulator cleared, beat count=0
  - any partial word or pending output is discarded; no flush output is generated
- Internal state:
  - Accumulator word and keep mask.
  - Beat count cnt, ranging 0..RATIO-1, width clog2(RATIO).
  - One output register (data_out/keep_out/valid_out).
- Lane of beat number cnt:
  - MSB_FIRST=1: lane RATIO-1-cnt.
  - MSB_FIRST=0: lane cnt.
- Accept (valid_in && ready_in):
  - Writes the beat into its lane and sets the matching keep bit.
  - Increments cnt.
- Output register is "free" when valid_out=0 or (valid_out && ready_out) in the same cycle.
- Word close: on the edge where either condition holds:
  - a) a beat is accepted with cnt==RATIO-1 (full word), or
  - b) flush=1 and the accumulator holds >=1 beat, including a beat accepted this cycle.
- Effect of a word close:
  - Accumulator (with the current beat merged) moves to the output register; valid_out=1 from the next cycle.
  - Accumulator and keep are cleared and cnt returns to 0.
  - Unused lanes of a partial word read as 0.
- Latency: last beat accepted at edge N -> valid_out=1 in cycle N+1 (one clock).
- ready_in = !(close_pending && output register not free):
  - close_pending = (cnt==RATIO-1) || (flush && cnt>0).
  - Combinational path from ready_out to ready_in is allowed.
  - With no backpressure, throughput is one beat per clock and there are no bubbles at word boundaries.
- Flush with cnt==0 and no beat accepted: no-op, no empty word emitted.
- Flush while ready_in=0: the partial word is held; the close occurs on the first cycle the output frees.
- Output hold: when valid_out && !ready_out, data_out/keep_out/valid_out stay stable.
- Output consumed (valid_out && ready_out) with no new close: valid_out=0 next cycle; data_out/keep_out keep their last value.
- valid_in gaps: count and accumulator hold and the word completes later. There is no timeout.
- Width rules:
  - data_out width = IN_W*RATIO; keep_out width = RATIO.
  - No truncation; beats are never reordered within a lane.

Test Plan (IN_W=8, RATIO=4 unless noted):
- MSB_FIRST=1, ready_out=1, beats AA,BB,CC,DD on consecutive cycles -> cycle after DD: data_out=32'hAABBCCDD, keep_out=4'b1111, valid_out for exactly 1 cycle.
- MSB_FIRST=0, same beats followed back-to-back by 11,22,33,44 -> data_out=32'hDDCCBBAA, then 32'h44332211 on consecutive word slots; ready_in stays 1 throughout.
- MSB_FIRST=1, ready_out=0 after first word 01020304; send 05,06,07,08 -> ready_in drops when 08 is offered; data_out holds 01020304; ready_out=1 -> next cycle data_out=05060708.
- MSB_FIRST=1, beats 11,22 then flush=1 with valid_in=0 -> data_out=32'h11220000, keep_out=4'b1100. A second flush with cnt=0 produces no output.
- Beat 33 accepted in the same cycle as flush -> data_out=32'h33000000, keep_out=4'b1000. Beats with gaps 0A,-,0B,-,-,0C,0D -> 32'h0A0B0C0D.
- reset=1 after 3 beats with valid_out=1 held by backpressure -> next cycle valid_out=0, data_out=0, keep_out=0. Next 4 beats form a clean word with no stale lanes.

Source files
------------

// File: rtl/paso_n_a_m_param.sv
// Packs RATIO consecutive IN_W-bit beats into one wide word with valid/ready on both sides.
// A flush closes a partial word early; keep_out marks which lanes carry real beats.
module paso_n_a_m_param #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned RATIO     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic [IN_W-1:0]         data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic                    flush,
    output logic [IN_W*RATIO-1:0]   data_out,
    output logic [RATIO-1:0]        keep_out,
    output logic                    valid_out,
    input  logic                    ready_out
);

    localparam int unsigned     CW   = $clog2(RATIO);
    localparam logic [CW-1:0]   LAST = CW'(RATIO - 1);

    logic [IN_W*RATIO-1:0] acc_q, acc_d, acc_m;
    logic [RATIO-1:0]      keep_q, keep_d, keep_m;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IN_W*RATIO-1:0] data_out_q, data_out_d;
    logic [RATIO-1:0]      keep_out_q, keep_out_d;
    logic                  valid_out_q, valid_out_d;

    logic          out_free;
    logic          close_pending;
    logic          accept;
    logic          close;
    logic [CW-1:0] lane;

    always_comb begin
        out_free      = !valid_out_q || ready_out;
        close_pending = (cnt_q == LAST) || (flush && (cnt_q != '0));
        ready_in      = !(close_pending && !out_free);
        accept        = valid_in && ready_in;
        lane          = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

        // Accumulator with this cycle's beat merged, so a close can include it.
        acc_m  = acc_q;
        keep_m = keep_q;
        if (accept) begin
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (lane == CW'(k)) begin
                    acc_m[k*IN_W +: IN_W] = data_in;
                    keep_m[k]             = 1'b1;
                end
            end
        end

        // A flush-close needs at least one beat; a flush with an empty
        // accumulator and no beat this cycle is a no-op.
        close = out_free &&
                ((accept && (cnt_q == LAST)) ||
                 (flush && ((cnt_q != '0) || accept)));

        acc_d       = acc_q;
        keep_d      = keep_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        valid_out_d = valid_out_q;

        if (close) begin
            data_out_d  = acc_m;
            keep_out_d  = keep_m;
            valid_out_d = 1'b1;
            acc_d       = '0;
            keep_d      = '0;
            cnt_d       = '0;
        end else begin
            if (accept) begin
                acc_d  = acc_m;
                keep_d = keep_m;
                cnt_d  = cnt_q + CW'(1);
            end
            if (valid_out_q && ready_out) begin
                valid_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            acc_q       <= '0;
            keep_q      <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            keep_q      <= keep_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_paso_n_a_m_param.sv
// Directed bench: two packers (MSB-first and LSB-first lane order) share one stimulus stream.
module tb_paso_n_a_m_param;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        flush;
    logic        ready_out;

    logic        ready_in_m, ready_in_l;
    logic [31:0] data_out_m, data_out_l;
    logic [3:0]  keep_out_m, keep_out_l;
    logic        valid_out_m, valid_out_l;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk_4f = ~clk_4f;

    paso_n_a_m_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) dut_m (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in_m), .flush(flush), .data_out(data_out_m),
        .keep_out(keep_out_m), .valid_out(valid_out_m), .ready_out(ready_out)
    );

    paso_n_a_m_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) dut_l (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in_l), .flush(flush), .data_out(data_out_l),
        .keep_out(keep_out_l), .valid_out(valid_out_l), .ready_out(ready_out)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        data_in  = d;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_out = 1'b1; data_in = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (valid_out_m !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out_m); else passed++;
        total++; if (data_out_m !== 32'h0) $display("FAIL reset_data: got %h want 00000000", data_out_m); else passed++;
        total++; if (keep_out_m !== 4'b0000) $display("FAIL reset_keep: got %b want 0000", keep_out_m); else passed++;
        total++; if (ready_in_m !== 1'b1) $display("FAIL reset_ready_in: got %b want 1", ready_in_m); else passed++;
    endtask

    task automatic test_full_word();
        beat(8'hAA); beat(8'hBB); beat(8'hCC); beat(8'hDD);
        total++; if (valid_out_m !== 1'b1) $display("FAIL full_valid: got %b want 1", valid_out_m); else passed++;
        total++; if (data_out_m !== 32'hAABBCCDD) $display("FAIL full_data_msb: got %h want aabbccdd", data_out_m); else passed++;
        total++; if (keep_out_m !== 4'b1111) $display("FAIL full_keep: got %b want 1111", keep_out_m); else passed++;
        total++; if (data_out_l !== 32'hDDCCBBAA) $display("FAIL full_data_lsb: got %h want ddccbbaa", data_out_l); else passed++;
        tick();
        total++; if (valid_out_m !== 1'b0) $display("FAIL full_valid_one_cycle: got %b want 0", valid_out_m); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [8];
        int unsigned ready_drops;
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        ready_drops = 0;
        ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = seq[i]; valid_in = 1'b1;
            #1;
            if (ready_in_l !== 1'b1) ready_drops++;
            tick();
            if (i == 3) begin
                total++; if (valid_out_l !== 1'b1 || data_out_l !== 32'hDDCCBBAA)
                    $display("FAIL b2b_word0: got v=%b %h want v=1 ddccbbaa", valid_out_l, data_out_l); else passed++;
            end
            if (i == 4) begin
                total++; if (valid_out_l !== 1'b0) $display("FAIL b2b_gap_valid: got %b want 0", valid_out_l); else passed++;
            end
        end
        valid_in = 1'b0;
        total++; if (valid_out_l !== 1'b1 || data_out_l !== 32'h44332211)
            $display("FAIL b2b_word1: got v=%b %h want v=1 44332211", valid_out_l, data_out_l); else passed++;
        total++; if (ready_drops != 0) $display("FAIL b2b_ready_in: got %0d drops want 0", ready_drops); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        ready_out = 1'b1;
        beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
        ready_out = 1'b0;
        total++; if (data_out_m !== 32'h01020304) $display("FAIL bp_word0: got %h want 01020304", data_out_m); else passed++;
        beat(8'h05); beat(8'h06); beat(8'h07);
        data_in = 8'h08; valid_in = 1'b1;
        #1;
        total++; if (ready_in_m !== 1'b0) $display("FAIL bp_ready_drop: got %b want 0", ready_in_m); else passed++;
        tick();
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'h01020304)
            $display("FAIL bp_hold: got v=%b %h want v=1 01020304", valid_out_m, data_out_m); else passed++;
        ready_out = 1'b1;
        #1;
        total++; if (ready_in_m !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", ready_in_m); else passed++;
        tick();
        valid_in = 1'b0;
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'h05060708)
            $display("FAIL bp_word1: got v=%b %h want v=1 05060708", valid_out_m, data_out_m); else passed++;
        tick();
        total++; if (valid_out_m !== 1'b0) $display("FAIL bp_drain: got %b want 0", valid_out_m); else passed++;
    endtask

    task automatic test_flush();
        ready_out = 1'b1;
        beat(8'h11); beat(8'h22);
        flush = 1'b1;
        tick();
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'h11220000 || keep_out_m !== 4'b1100)
            $display("FAIL flush_partial_msb: got v=%b %h k=%b want v=1 11220000 k=1100", valid_out_m, data_out_m, keep_out_m); else passed++;
        total++; if (data_out_l !== 32'h00002211 || keep_out_l !== 4'b0011)
            $display("FAIL flush_partial_lsb: got %h k=%b want 00002211 k=0011", data_out_l, keep_out_l); else passed++;
        tick();
        flush = 1'b0;
        total++; if (valid_out_m !== 1'b0) $display("FAIL flush_empty_noop: got %b want 0", valid_out_m); else passed++;
    endtask

    task automatic test_flush_with_beat();
        ready_out = 1'b1;
        flush = 1'b1;
        beat(8'h33);
        flush = 1'b0;
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'h33000000 || keep_out_m !== 4'b1000)
            $display("FAIL flush_same_beat: got v=%b %h k=%b want v=1 33000000 k=1000", valid_out_m, data_out_m, keep_out_m); else passed++;
        beat(8'h0A); tick(); beat(8'h0B); tick(); tick(); beat(8'h0C);
        total++; if (valid_out_m !== 1'b0) $display("FAIL gap_no_early_word: got %b want 0", valid_out_m); else passed++;
        beat(8'h0D);
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'h0A0B0C0D || keep_out_m !== 4'b1111)
            $display("FAIL gap_word: got v=%b %h k=%b want v=1 0a0b0c0d k=1111", valid_out_m, data_out_m, keep_out_m); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        ready_out = 1'b1;
        beat(8'hA1); beat(8'hA2); beat(8'hA3); beat(8'hA4);
        ready_out = 1'b0;
        beat(8'hB1); beat(8'hB2); beat(8'hB3);
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'hA1A2A3A4)
            $display("FAIL rst_mid_pre: got v=%b %h want v=1 a1a2a3a4", valid_out_m, data_out_m); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (valid_out_m !== 1'b0 || data_out_m !== 32'h0 || keep_out_m !== 4'b0000)
            $display("FAIL rst_mid_clear: got v=%b %h k=%b want v=0 00000000 k=0000", valid_out_m, data_out_m, keep_out_m); else passed++;
        ready_out = 1'b1;
        beat(8'hC1); beat(8'hC2); beat(8'hC3);
        total++; if (valid_out_m !== 1'b0) $display("FAIL rst_mid_no_stale_close: got %b want 0", valid_out_m); else passed++;
        beat(8'hC4);
        total++; if (valid_out_m !== 1'b1 || data_out_m !== 32'hC1C2C3C4 || keep_out_m !== 4'b1111)
            $display("FAIL rst_mid_clean_word: got v=%b %h k=%b want v=1 c1c2c3c4 k=1111", valid_out_m, data_out_m, keep_out_m); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_flush_with_beat();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
